// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor: mode encoding,
// default geometry and the per-stage slice width helper.
package pipe_adder_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // Bits handled by one pipeline slice.
    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// master = producer/consumer side, slave = the adder itself.
interface pipe_adder_if
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_1;
    logic [WIDTH-1:0] in_2;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             count;
    logic             ovf;

    modport master (
        output in_valid, in_1, in_2, cin, sub, out_ready,
        input  in_ready, out_valid, sum, count, ovf
    );

    modport slave (
        input  in_valid, in_1, in_2, cin, sub, out_ready,
        output in_ready, out_valid, sum, count, ovf
    );

endinterface

// File: rtl/slice_adder.sv
// Combinational W-bit ripple adder built from 1-bit full-adder cells.
module slice_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    assign c[0] = ci;

    // One full-adder cell per bit, carry rippling upward.
    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[W];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor. A WIDTH-bit add is split into STAGES slices;
// slice k adds its CHUNK bits plus the carry registered by slice k-1.
// Untouched upper operand bits ride skew registers that shrink each stage,
// finished lower sum bits ride a growing delay register. One global
// advance signal stalls the whole pipe when the result is not taken.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    pipe_adder_if.slave  bus
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;

    if (WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_bad_param
        $error("pipe_adder: WIDTH must be >= 2 and a multiple of STAGES");
    end

    logic [STAGES:1]  vld_pipe;
    logic             advance;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             c0;

    assign advance      = !vld_pipe[STAGES] || bus.out_ready;
    assign bus.in_ready = advance;

    // Operands are zeroed under in_valid=0 so bubbles never carry X toward sum.
    assign a0 = bus.in_valid ? bus.in_1 : '0;
    assign b0 = !bus.in_valid ? '0 : ((bus.sub == MODE_SUB) ? ~bus.in_2 : bus.in_2);
    assign c0 = bus.in_valid & ((bus.sub == MODE_SUB) ? 1'b1 : bus.cin);

    // Valid shift register; holds with the data on a stall.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            vld_pipe <= '0;
        end else if (advance) begin
            vld_pipe[1] <= bus.in_valid;
            for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * CHUNK;

        logic [WIDTH-1:LO]     a_i;
        logic [WIDTH-1:LO]     b_i;
        logic                  c_i;
        logic [CHUNK-1:0]      s_sl;
        logic                  co;
        logic [LO+CHUNK-1:0]   s_q;
        logic                  c_q;

        if (k == 0) begin : g_in
            assign a_i = a0;
            assign b_i = b0;
            assign c_i = c0;
        end else begin : g_in
            assign a_i = g_stg[k-1].g_skew.a_q;
            assign b_i = g_stg[k-1].g_skew.b_q;
            assign c_i = g_stg[k-1].c_q;
        end

        slice_adder #(.W(CHUNK)) u_slice (
            .a  (a_i[LO +: CHUNK]),
            .b  (b_i[LO +: CHUNK]),
            .ci (c_i),
            .s  (s_sl),
            .co (co)
        );

        // Slice carry out feeds the next slice.
        always_ff @(posedge sys_clk) begin
            if (sys_rst)      c_q <= 1'b0;
            else if (advance) c_q <= co;
        end

        if (k == 0) begin : g_sum
            // First slice starts the aligned result.
            always_ff @(posedge sys_clk) begin
                if (sys_rst)      s_q <= '0;
                else if (advance) s_q <= s_sl;
            end
        end else begin : g_sum
            // New slice lands on top of the already-finished lower bits.
            always_ff @(posedge sys_clk) begin
                if (sys_rst)      s_q <= '0;
                else if (advance) s_q <= {s_sl, g_stg[k-1].s_q};
            end
        end

        if (k < LAST) begin : g_skew
            logic [WIDTH-1:LO+CHUNK] a_q;
            logic [WIDTH-1:LO+CHUNK] b_q;

            // Operand bits not yet consumed travel with the beat.
            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_i[WIDTH-1:LO+CHUNK];
                    b_q <= b_i[WIDTH-1:LO+CHUNK];
                end
            end
        end else begin : g_last
            logic o_q;

            // Signed overflow: operands agree in sign, result sign differs.
            always_ff @(posedge sys_clk) begin
                if (sys_rst)      o_q <= 1'b0;
                else if (advance) o_q <= (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                                         (s_sl[CHUNK-1] != a_i[WIDTH-1]);
            end
        end
    end

    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.sum       = g_stg[LAST].s_q;
    assign bus.count     = g_stg[LAST].c_q;
    assign bus.ovf       = g_stg[LAST].g_last.o_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: three instances (STAGES = 1, 4, 16) share one
// stimulus stream; each has its own scoreboard fed by a signed/unsigned
// integer reference model.
module tb_pipe_adder;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : (d == 1) ? 4 : 16;
    endfunction

    logic sys_clk = 1'b0;
    logic sys_rst;
    always #5 sys_clk = ~sys_clk;

    logic         d_v, d_cin, d_sub, d_ordy;
    logic [W-1:0] d_a, d_b;

    logic         ov [3];
    logic         ir [3];
    logic         oc [3];
    logic         oo [3];
    logic [W-1:0] os [3];

    pipe_adder_if #(.WIDTH(W)) bus [3] ();

    for (genvar i = 0; i < 3; i++) begin : g_dut
        assign bus[i].in_valid  = d_v;
        assign bus[i].in_1      = d_a;
        assign bus[i].in_2      = d_b;
        assign bus[i].cin       = d_cin;
        assign bus[i].sub       = d_sub;
        assign bus[i].out_ready = d_ordy;
        assign ov[i] = bus[i].out_valid;
        assign ir[i] = bus[i].in_ready;
        assign os[i] = bus[i].sum;
        assign oc[i] = bus[i].count;
        assign oo[i] = bus[i].ovf;

        pipe_adder #(.WIDTH(W), .STAGES(lat(i))) u_dut (
            .sys_clk (sys_clk),
            .sys_rst (sys_rst),
            .bus     (bus[i])
        );
    end

    int   n_cmp = 0;
    int   n_err = 0;
    res_t sb [3][$];
    logic p_ov [3];
    res_t p_res [3];
    logic p_ordy = 1'b1;
    logic p_rst  = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s);
        res_t r;
        int   t;
        if (s) begin
            t   = int'($signed(a)) - int'($signed(b));
            r.s = a - b;
            r.c = (a >= b);
        end else begin
            t   = int'($signed(a)) + int'($signed(b)) + int'(c);
            r.s = a + b + {15'b0, c};
            r.c = ({16'b0, a} + {16'b0, b} + {31'b0, c}) > 32'h0000_FFFF;
        end
        r.o = (t > 32767) || (t < -32768);
        return r;
    endfunction

    // One clock: drive at negedge, check outputs and handshake, update scoreboards.
    task automatic step(input logic rst_v, input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c, input logic s,
                        input logic ordy, output logic acc);
        res_t got, exp;
        @(negedge sys_clk);
        sys_rst = rst_v;
        d_v = v; d_a = a; d_b = b; d_cin = c; d_sub = s; d_ordy = ordy;
        #1;
        for (int d = 0; d < 3; d++) begin
            got = {os[d], oc[d], oo[d]};
            chk($sformatf("in_ready[%0d]", d), 32'(ir[d]), 32'(!ov[d] || ordy));
            if (p_ov[d] === 1'b1 && !p_ordy && !p_rst) begin
                chk($sformatf("hold_valid[%0d]", d), 32'(ov[d]), 32'd1);
                chk($sformatf("hold_data[%0d]", d), 32'(got), 32'(p_res[d]));
            end
            if (ov[d] === 1'b1 && ordy) begin
                chk($sformatf("sb_nonempty[%0d]", d), 32'(sb[d].size() != 0), 32'd1);
                if (sb[d].size() != 0) begin
                    exp = sb[d].pop_front();
                    chk($sformatf("result[%0d]", d), 32'(got), 32'(exp));
                end
            end
            if (rst_v) sb[d].delete();
            else if (v && ir[d]) sb[d].push_back(model(a, b, c, s));
            p_ov[d]  = ov[d];
            p_res[d] = got;
        end
        p_ordy = ordy;
        p_rst  = rst_v;
        acc    = v && !rst_v && ir[1];
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic         acc;
        int           k, idx, t;
        logic [W-1:0] ra [10];
        logic [W-1:0] rb [10];
        logic         rc [10];
        logic         rs [10];
        logic [W-1:0] ta [5];
        logic [W-1:0] tb [5];
        logic         tc [5];
        logic         ts [5];
        res_t         te [5];

        sys_rst = 1'b1;
        d_v = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0; d_ordy = 1'b1;

        // Reset held two cycles with in_valid high.
        step(1, 1, 16'h1111, 16'h2222, 0, 0, 1, acc);
        step(1, 1, 16'h1111, 16'h2222, 0, 0, 1, acc);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_valid[%0d]", d), 32'(ov[d]), 32'd0);
            chk($sformatf("rst_sum[%0d]", d), 32'(os[d]), 32'd0);
            chk($sformatf("rst_count[%0d]", d), 32'(oc[d]), 32'd0);
            chk($sformatf("rst_ovf[%0d]", d), 32'(oo[d]), 32'd0);
        end
        step(0, 0, '0, '0, 0, 0, 1, acc);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("post_rst_valid[%0d]", d), 32'(ov[d]), 32'd0);
            chk($sformatf("post_rst_ready[%0d]", d), 32'(ir[d]), 32'd1);
        end

        // Single add: exact latency per depth, one-cycle valid pulse.
        step(0, 1, 16'h1234, 16'h0FCC, 1, 0, 1, acc);
        chk("single_accept", 32'(acc), 32'd1);
        for (int i = 1; i <= 18; i++) begin
            step(0, 0, '0, '0, 0, 0, 1, acc);
            for (int d = 0; d < 3; d++)
                chk($sformatf("lat_valid[%0d]@%0d", d, i), 32'(ov[d]), 32'(i == lat(d)));
            if (i == 4) begin
                chk("add_sum", 32'(os[1]), 32'h2201);
                chk("add_count", 32'(oc[1]), 32'd0);
                chk("add_ovf", 32'(oo[1]), 32'd0);
            end
        end

        // Directed carry/borrow/overflow corners streamed back to back.
        ta = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0005};
        tb = '{16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0003};
        tc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ts = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        te = '{'{16'h0000, 1'b1, 1'b0}, '{16'h8000, 1'b0, 1'b1},
               '{16'hFFFE, 1'b0, 1'b0}, '{16'h7FFF, 1'b1, 1'b1},
               '{16'h0002, 1'b1, 1'b0}};
        k = 0;
        for (int j = 0; j < 25; j++) begin
            if (j < 5) step(0, 1, ta[j], tb[j], tc[j], ts[j], 1, acc);
            else       step(0, 0, '0, '0, 0, 0, 1, acc);
            if (ov[1] === 1'b1 && k < 5) begin
                chk($sformatf("dir_sum%0d", k), 32'(os[1]), 32'(te[k].s));
                chk($sformatf("dir_count%0d", k), 32'(oc[1]), 32'(te[k].c));
                chk($sformatf("dir_ovf%0d", k), 32'(oo[1]), 32'(te[k].o));
                k++;
            end
        end
        chk("dir_results", 32'(k), 32'd5);

        // Back-pressure: 10 random beats, out_ready low for 6 cycles mid-stream.
        for (int i = 0; i < 10; i++) begin
            ra[i] = 16'($urandom);
            rb[i] = 16'($urandom);
            rc[i] = 1'($urandom_range(0, 1));
            rs[i] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        t = 0;
        while ((idx < 10 || t < 12) && t < 200) begin
            if (idx < 10) step(0, 1, ra[idx], rb[idx], rc[idx], rs[idx], !(t >= 3 && t < 9), acc);
            else          step(0, 0, '0, '0, 0, 0, !(t >= 3 && t < 9), acc);
            if (acc) idx++;
            t++;
        end
        chk("bp_accepted", 32'(idx), 32'd10);
        for (int i = 0; i < 24; i++) step(0, 0, '0, '0, 0, 0, 1, acc);
        for (int d = 0; d < 3; d++)
            chk($sformatf("bp_drained[%0d]", d), 32'(sb[d].size()), 32'd0);

        // Reset mid-flight: three beats in the pipe, then a one-cycle reset.
        for (int i = 0; i < 3; i++)
            step(0, 1, 16'(16'h1000 * (i + 1)), 16'h0123, 0, 0, 1, acc);
        step(1, 0, '0, '0, 0, 0, 1, acc);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, '0, '0, 0, 0, 1, acc);
            for (int d = 0; d < 3; d++)
                chk($sformatf("flush_quiet[%0d]@%0d", d, i), 32'(ov[d]), 32'd0);
        end
        step(0, 1, 16'h00FF, 16'h0101, 0, 0, 1, acc);
        for (int i = 0; i < 20; i++) step(0, 0, '0, '0, 0, 0, 1, acc);
        for (int d = 0; d < 3; d++)
            chk($sformatf("flush_drained[%0d]", d), 32'(sb[d].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
